// File: rtl/mpy_arbiter.sv
// rtl/mpy_arbiter.sv - round-robin sequencer sharing one slow multiplier among NREQ requesters
// Grants one operand pair at a time, waits for the product, and aborts hung multiplies via a watchdog.
module mpy_arbiter #(
    parameter int NREQ      = 4,
    parameter int LGNREQ    = 2,
    parameter int NA        = 33,
    parameter int LGTIMEOUT = 7
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic [NREQ-1:0]      i_req_stb,
    input  logic [NREQ*NA-1:0]   i_req_a,
    input  logic [NREQ*NA-1:0]   i_req_b,
    output logic [NREQ-1:0]      o_req_ack,
    output logic                 o_rsp_valid,
    output logic [LGNREQ-1:0]    o_rsp_id,
    output logic [2*NA-1:0]      o_rsp_p,
    output logic                 o_rsp_err,
    output logic                 o_busy,
    output logic                 o_mpy_reset,
    output logic                 o_mpy_stb,
    output logic [NA-1:0]        o_mpy_a,
    output logic [NA-1:0]        o_mpy_b,
    input  logic                 i_mpy_busy,
    input  logic                 i_mpy_done,
    input  logic [2*NA-1:0]      i_mpy_p
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ABORT = 2'd3
    } state_t;

    localparam logic [LGTIMEOUT-1:0] WD_MAX = '1;
    localparam logic [NREQ-1:0]      ONE_HOT0 = {{(NREQ-1){1'b0}}, 1'b1};

    state_t                 r_state;
    logic [LGNREQ-1:0]      r_last;
    logic [LGNREQ-1:0]      r_id;
    logic [LGTIMEOUT-1:0]   r_wdog;
    logic [NREQ-1:0]        r_req_ack;
    logic                   r_rsp_valid;
    logic [LGNREQ-1:0]      r_rsp_id;
    logic [2*NA-1:0]        r_rsp_p;
    logic                   r_rsp_err;
    logic                   r_mpy_reset;
    logic                   r_mpy_stb;
    logic [NA-1:0]          r_mpy_a;
    logic [NA-1:0]          r_mpy_b;

    logic                   w_grant_vld;
    logic [LGNREQ-1:0]      w_grant;
    int                     w_idx;

    // Search last+1, last+2, ... with wrap; scanning from the far end lets the nearest hit win.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = '0;
        w_idx       = 0;
        for (int i = NREQ; i >= 1; i--) begin
            w_idx = int'(r_last) + i;
            if (w_idx >= NREQ)
                w_idx = w_idx - NREQ;
            if (i_req_stb[w_idx]) begin
                w_grant_vld = 1'b1;
                w_grant     = LGNREQ'(w_idx);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= S_IDLE;
            r_last      <= LGNREQ'(NREQ - 1);
            r_id        <= '0;
            r_wdog      <= '0;
            r_req_ack   <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_p     <= '0;
            r_rsp_err   <= 1'b0;
            r_mpy_reset <= 1'b1;
            r_mpy_stb   <= 1'b0;
            r_mpy_a     <= '0;
            r_mpy_b     <= '0;
        end else begin
            r_req_ack   <= '0;
            r_rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_mpy_reset <= 1'b0;
                    if (w_grant_vld && !i_mpy_busy && !r_mpy_reset) begin
                        r_mpy_a   <= i_req_a[w_grant*NA +: NA];
                        r_mpy_b   <= i_req_b[w_grant*NA +: NA];
                        r_id      <= w_grant;
                        r_last    <= w_grant;
                        r_req_ack <= ONE_HOT0 << w_grant;
                        r_mpy_stb <= 1'b1;
                        r_wdog    <= '0;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_mpy_stb <= 1'b0;
                    if (i_mpy_busy) begin
                        // The first WAIT cycle counts as one, so expiry lands on the 2^LGTIMEOUT-1'th WAIT cycle.
                        r_wdog  <= LGTIMEOUT'(1);
                        r_state <= S_WAIT;
                    end else if (r_wdog == WD_MAX) begin
                        r_mpy_reset <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_p     <= '0;
                        r_rsp_id    <= r_id;
                        r_wdog      <= '0;
                        r_state     <= S_ABORT;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (i_mpy_done) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_p     <= i_mpy_p;
                        r_rsp_id    <= r_id;
                        r_state     <= S_IDLE;
                    end else if (r_wdog == WD_MAX) begin
                        r_mpy_reset <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_rsp_p     <= '0;
                        r_rsp_id    <= r_id;
                        r_wdog      <= '0;
                        r_state     <= S_ABORT;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                S_ABORT: begin
                    // Multiplier reset is held for two cycles, counted in the watchdog register.
                    if (r_wdog[0]) begin
                        r_mpy_reset <= 1'b0;
                        r_wdog      <= '0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_req_ack   = r_req_ack;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_id    = r_rsp_id;
    assign o_rsp_p     = r_rsp_p;
    assign o_rsp_err   = r_rsp_err;
    assign o_busy      = (r_state != S_IDLE);
    assign o_mpy_reset = r_mpy_reset;
    assign o_mpy_stb   = r_mpy_stb;
    assign o_mpy_a     = r_mpy_a;
    assign o_mpy_b     = r_mpy_b;

endmodule
